// File: rtl/platform_arbiter.sv
// Platform geometry table shared by two character controllers through a
// round-robin req/ack scan, plus a registered per-pixel platform mask.
module platform_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [10:0] x0,
  input  logic [10:0] y0,
  input  logic [10:0] x1,
  input  logic [10:0] y1,
  output logic        ack0,
  output logic        ack1,
  output logic        res_hit,
  output logic [2:0]  res_idx,
  output logic [10:0] res_ytop,
  output logic        busy,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_idx,
  input  logic        cfg_en,
  input  logic [10:0] cfg_xmin,
  input  logic [10:0] cfg_xmax,
  input  logic [10:0] cfg_ytop,
  input  logic [10:0] cfg_ybot,
  output logic        cfg_ready,
  input  logic [10:0] pix_hcount,
  input  logic [10:0] pix_vcount,
  output logic        pix_on
);

  localparam int NUM_PLAT = 8;

  localparam logic [NUM_PLAT-1:0] DEF_EN = 8'b0011_1111;
  localparam logic [10:0] DEF_XMIN [NUM_PLAT] =
    '{11'd181, 11'd781, 11'd1,   11'd501, 11'd601, 11'd126, 11'd0, 11'd0};
  localparam logic [10:0] DEF_XMAX [NUM_PLAT] =
    '{11'd649, 11'd919, 11'd249, 11'd599, 11'd974, 11'd449, 11'd0, 11'd0};
  localparam logic [10:0] DEF_YTOP [NUM_PLAT] =
    '{11'd596, 11'd596, 11'd456, 11'd456, 11'd316, 11'd216, 11'd0, 11'd0};
  localparam logic [10:0] DEF_YBOT [NUM_PLAT] =
    '{11'd604, 11'd604, 11'd464, 11'd464, 11'd324, 11'd224, 11'd0, 11'd0};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state_reg;
  logic [2:0]  scan_idx_reg;
  logic        gnt_reg;
  logic        last_served_reg;
  logic [10:0] qx_reg;
  logic [10:0] qy_reg;
  logic        acc_hit_reg;
  logic [2:0]  acc_idx_reg;
  logic [10:0] acc_ytop_reg;

  logic                tbl_en   [NUM_PLAT];
  logic [10:0]         tbl_xmin [NUM_PLAT];
  logic [10:0]         tbl_xmax [NUM_PLAT];
  logic [10:0]         tbl_ytop [NUM_PLAT];
  logic [10:0]         tbl_ybot [NUM_PLAT];
  logic [NUM_PLAT-1:0] pix_match;

  function automatic logic in_rect(input logic en,
                                   input logic [10:0] xmin, xmax, ytop, ybot,
                                   input logic [10:0] x, y);
    return en && (x >= xmin) && (x <= xmax) && (y >= ytop) && (y <= ybot);
  endfunction

  logic        cfg_write;
  logic        any_req;
  logic        gnt_next;
  logic        cur_match;
  logic        take;
  logic        acc_hit_next;
  logic [2:0]  acc_idx_next;
  logic [10:0] acc_ytop_next;

  assign cfg_write = cfg_we && (state_reg == IDLE);
  assign any_req   = req0 || req1;
  // On a tie the requester not served last wins; otherwise whoever asks.
  assign gnt_next  = (req0 && req1) ? ~last_served_reg : req1;

  assign cur_match = in_rect(tbl_en[scan_idx_reg], tbl_xmin[scan_idx_reg],
                             tbl_xmax[scan_idx_reg], tbl_ytop[scan_idx_reg],
                             tbl_ybot[scan_idx_reg], qx_reg, qy_reg);
  assign take          = cur_match && !acc_hit_reg;
  assign acc_hit_next  = acc_hit_reg || cur_match;
  assign acc_idx_next  = take ? scan_idx_reg : acc_idx_reg;
  assign acc_ytop_next = take ? tbl_ytop[scan_idx_reg] : acc_ytop_reg;

  assign busy      = (state_reg != IDLE);
  assign cfg_ready = (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        tbl_en[i]   <= DEF_EN[i];
        tbl_xmin[i] <= DEF_XMIN[i];
        tbl_xmax[i] <= DEF_XMAX[i];
        tbl_ytop[i] <= DEF_YTOP[i];
        tbl_ybot[i] <= DEF_YBOT[i];
      end
    end else if (cfg_write) begin
      tbl_en[cfg_idx]   <= cfg_en;
      tbl_xmin[cfg_idx] <= cfg_xmin;
      tbl_xmax[cfg_idx] <= cfg_xmax;
      tbl_ytop[cfg_idx] <= cfg_ytop;
      tbl_ybot[cfg_idx] <= cfg_ybot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      scan_idx_reg    <= 3'd0;
      gnt_reg         <= 1'b0;
      last_served_reg <= 1'b1;
      qx_reg          <= 11'd0;
      qy_reg          <= 11'd0;
      acc_hit_reg     <= 1'b0;
      acc_idx_reg     <= 3'd0;
      acc_ytop_reg    <= 11'd0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      res_hit         <= 1'b0;
      res_idx         <= 3'd0;
      res_ytop        <= 11'd0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!cfg_we && any_req) begin
            state_reg       <= SCAN;
            gnt_reg         <= gnt_next;
            last_served_reg <= gnt_next;
            qx_reg          <= gnt_next ? x1 : x0;
            qy_reg          <= gnt_next ? y1 : y0;
            scan_idx_reg    <= 3'd0;
            acc_hit_reg     <= 1'b0;
            acc_idx_reg     <= 3'd0;
            acc_ytop_reg    <= 11'd0;
          end
        end
        SCAN: begin
          acc_hit_reg  <= acc_hit_next;
          acc_idx_reg  <= acc_idx_next;
          acc_ytop_reg <= acc_ytop_next;
          scan_idx_reg <= scan_idx_reg + 3'd1;
          if (scan_idx_reg == 3'd7) state_reg <= DONE;
        end
        DONE: begin
          ack0      <= ~gnt_reg;
          ack1      <= gnt_reg;
          res_hit   <= acc_hit_reg;
          res_idx   <= acc_idx_reg;
          res_ytop  <= acc_ytop_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Pixel mask looks at the live table, so a write lands on the very next pixel.
  generate
    for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_pix
      assign pix_match[gi] = in_rect(tbl_en[gi], tbl_xmin[gi], tbl_xmax[gi],
                                     tbl_ytop[gi], tbl_ybot[gi],
                                     pix_hcount, pix_vcount);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) pix_on <= 1'b0;
    else     pix_on <= |pix_match;
  end

endmodule

// File: tb/tb_platform_arbiter.sv
// Randomized bench for platform_arbiter against a table-lookup reference model.
module tb_platform_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [10:0] x0, y0, x1, y1;
  logic        ack0, ack1;
  logic        res_hit;
  logic [2:0]  res_idx;
  logic [10:0] res_ytop;
  logic        busy;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic        cfg_en;
  logic [10:0] cfg_xmin, cfg_xmax, cfg_ytop, cfg_ybot;
  logic        cfg_ready;
  logic [10:0] pix_hcount, pix_vcount;
  logic        pix_on;

  platform_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .ack0(ack0), .ack1(ack1),
    .res_hit(res_hit), .res_idx(res_idx), .res_ytop(res_ytop), .busy(busy),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_xmin(cfg_xmin), .cfg_xmax(cfg_xmax), .cfg_ytop(cfg_ytop), .cfg_ybot(cfg_ybot),
    .cfg_ready(cfg_ready),
    .pix_hcount(pix_hcount), .pix_vcount(pix_vcount), .pix_on(pix_on)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_total = 0;

  always @(posedge clk) begin
    cyc_total++;
    if (cyc_total > 50000) begin
      $display("FAIL global_timeout: cycles %0d limit 50000", cyc_total);
      $fatal(1, "global timeout");
    end
  end

  // Reference model: the platform list plus who was served last.
  bit          m_en   [8];
  logic [10:0] m_xmin [8];
  logic [10:0] m_xmax [8];
  logic [10:0] m_ytop [8];
  logic [10:0] m_ybot [8];
  int          m_last;

  task automatic model_reset();
    m_en   = '{1, 1, 1, 1, 1, 1, 0, 0};
    m_xmin = '{181, 781, 1, 501, 601, 126, 0, 0};
    m_xmax = '{649, 919, 249, 599, 974, 449, 0, 0};
    m_ytop = '{596, 596, 456, 456, 316, 216, 0, 0};
    m_ybot = '{604, 604, 464, 464, 324, 224, 0, 0};
    m_last = 1;
  endtask

  task automatic ref_query(input logic [10:0] qx, input logic [10:0] qy,
                           output logic hit, output logic [2:0] idx,
                           output logic [10:0] ytop);
    hit = 0; idx = 0; ytop = 0;
    for (int i = 7; i >= 0; i--) begin
      if (m_en[i] && qx >= m_xmin[i] && qx <= m_xmax[i] &&
          qy >= m_ytop[i] && qy <= m_ybot[i]) begin
        hit = 1; idx = 3'(i); ytop = m_ytop[i];
      end
    end
  endtask

  function automatic logic ref_pix(input logic [10:0] h, input logic [10:0] v);
    logic on = 0;
    for (int i = 0; i < 8; i++)
      if (m_en[i] && h >= m_xmin[i] && h <= m_xmax[i] && v >= m_ytop[i] && v <= m_ybot[i])
        on = 1;
    return on;
  endfunction

  // Caller is at a negedge with the DUT in IDLE.
  task automatic cfg_write(input int idx, input bit en, input int xmin, input int xmax,
                           input int ytop, input int ybot);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_en = en;
    cfg_xmin = 11'(xmin); cfg_xmax = 11'(xmax); cfg_ytop = 11'(ytop); cfg_ybot = 11'(ybot);
    @(negedge clk);
    cfg_we = 0;
    m_en[idx] = en; m_xmin[idx] = 11'(xmin); m_xmax[idx] = 11'(xmax);
    m_ytop[idx] = 11'(ytop); m_ybot[idx] = 11'(ybot);
  endtask

  // Issues one query from requester r and checks latency, ack routing and results.
  task automatic run_query(input int r, input logic [10:0] qx, input logic [10:0] qy);
    logic eh; logic [2:0] ei; logic [10:0] ey;
    int cyc = 0;
    bit got = 0, stray = 0;
    ref_query(qx, qy, eh, ei, ey);
    if (r == 0) begin req0 = 1; x0 = qx; y0 = qy; end
    else        begin req1 = 1; x1 = qx; y1 = qy; end
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (r == 0) begin x0 = 11'($urandom); y0 = 11'($urandom); end
        else        begin x1 = 11'($urandom); y1 = 11'($urandom); end
      end
      if ((r == 0 && ack1) || (r == 1 && ack0)) stray = 1;
      if ((r == 0 && ack0) || (r == 1 && ack1)) got = 1;
    end
    req0 = 0; req1 = 0;
    m_last = r;
    n_checks++;
    if (!got || cyc != 10)
      $display("FAIL query_latency r%0d (%0d,%0d): ack after %0d cycles (got=%0d) required 10", r, qx, qy, cyc, got);
    else n_pass++;
    n_checks++;
    if (stray) $display("FAIL query_other_ack r%0d: other ack pulsed, required silent", r);
    else n_pass++;
    n_checks++;
    if ({res_hit, res_idx, res_ytop} !== {eh, ei, ey})
      $display("FAIL query_result r%0d (%0d,%0d): hit=%0d idx=%0d ytop=%0d required hit=%0d idx=%0d ytop=%0d",
               r, qx, qy, res_hit, res_idx, res_ytop, eh, ei, ey);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1; req0 = 0; req1 = 0; x0 = 0; y0 = 0; x1 = 0; y1 = 0;
    cfg_we = 0; cfg_idx = 0; cfg_en = 0;
    cfg_xmin = 0; cfg_xmax = 0; cfg_ytop = 0; cfg_ybot = 0;
    pix_hcount = 0; pix_vcount = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_checks++;
    if ({ack0, ack1, res_hit, res_idx, res_ytop, busy, cfg_ready, pix_on} !== {1'b0, 1'b0, 1'b0, 3'd0, 11'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_state: ack0=%0d ack1=%0d hit=%0d idx=%0d ytop=%0d busy=%0d ready=%0d pix=%0d required 0,0,0,0,0,0,1,0",
               ack0, ack1, res_hit, res_idx, res_ytop, busy, cfg_ready, pix_on);
    else n_pass++;
  endtask

  task automatic test_single_hit();
    run_query(0, 11'd300, 11'd600);
  endtask

  task automatic test_gap();
    run_query(1, 11'd700, 11'd600);
  endtask

  // Both requests held throughout: grants must alternate every 10 cycles.
  task automatic test_tie();
    logic eh; logic [2:0] ei; logic [10:0] ey;
    int g;
    req0 = 1; x0 = 11'd300; y0 = 11'd600;
    req1 = 1; x1 = 11'd550; y1 = 11'd460;
    g = (m_last == 1) ? 0 : 1;
    for (int k = 0; k < 4; k++) begin
      int cyc = 0;
      bit got = 0;
      while (!got && cyc < 15) begin
        @(negedge clk);
        cyc++;
        if (ack0 || ack1) got = 1;
      end
      if (g == 0) ref_query(11'd300, 11'd600, eh, ei, ey);
      else        ref_query(11'd550, 11'd460, eh, ei, ey);
      n_checks++;
      if (!got || cyc != 10 || ack0 !== (g == 0) || ack1 !== (g == 1))
        $display("FAIL tie_grant round%0d: ack0=%0d ack1=%0d after %0d cycles required ack%0d after 10",
                 k, ack0, ack1, cyc, g);
      else n_pass++;
      n_checks++;
      if ({res_hit, res_idx, res_ytop} !== {eh, ei, ey})
        $display("FAIL tie_result round%0d: hit=%0d idx=%0d ytop=%0d required %0d/%0d/%0d",
                 k, res_hit, res_idx, res_ytop, eh, ei, ey);
      else n_pass++;
      m_last = g;
      g = 1 - g;
    end
    req0 = 0; req1 = 0;
  endtask

  // A write during a scan is dropped; the table keeps its contents.
  task automatic test_cfg_busy();
    int cyc = 0;
    bit got = 0;
    req0 = 1; x0 = 11'd300; y0 = 11'd600;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin
        n_checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0)
          $display("FAIL busy_flag: busy=%0d ready=%0d required 1,0", busy, cfg_ready);
        else n_pass++;
        cfg_we = 1; cfg_idx = 3'd0; cfg_en = 0;
        cfg_xmin = 0; cfg_xmax = 0; cfg_ytop = 0; cfg_ybot = 0;
      end
      if (cyc == 4) cfg_we = 0;
      if (ack0) got = 1;
    end
    req0 = 0;
    m_last = 0;
    n_checks++;
    if (!got || {res_hit, res_idx, res_ytop} !== {1'b1, 3'd0, 11'd596})
      $display("FAIL cfg_busy_query: got=%0d hit=%0d idx=%0d ytop=%0d required 1/0/596",
               got, res_hit, res_idx, res_ytop);
    else n_pass++;
    run_query(1, 11'd190, 11'd596);
  endtask

  task automatic test_pix();
    logic [10:0] hs [4];
    logic [10:0] vs [4];
    logic        es [4];
    hs = '{181, 180, 649, 650};
    vs = '{596, 596, 604, 604};
    es = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      pix_hcount = hs[i]; pix_vcount = vs[i];
      @(negedge clk);
      n_checks++;
      if (pix_on !== es[i])
        $display("FAIL pix_edge (%0d,%0d): pix_on=%0d required %0d", hs[i], vs[i], pix_on, es[i]);
      else n_pass++;
    end
  endtask

  task automatic test_cfg_priority();
    n_checks++;
    if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_idle: %0d required 1", cfg_ready);
    else n_pass++;
    cfg_write(6, 1, 200, 300, 590, 610);
    run_query(0, 11'd250, 11'd600);
    cfg_write(0, 0, 181, 649, 596, 604);
    run_query(1, 11'd250, 11'd600);
    pix_hcount = 11'd185; pix_vcount = 11'd600;
    @(negedge clk);
    n_checks++;
    if (pix_on !== ref_pix(11'd185, 11'd600))
      $display("FAIL pix_after_write: pix_on=%0d required %0d", pix_on, ref_pix(11'd185, 11'd600));
    else n_pass++;
  endtask

  task automatic test_random();
    logic [10:0] qx, qy;
    for (int n = 0; n < 30; n++) begin
      qx = 11'($urandom_range(0, 1100));
      case ($urandom_range(0, 4))
        0: qy = 11'($urandom_range(590, 610));
        1: qy = 11'($urandom_range(450, 470));
        2: qy = 11'($urandom_range(310, 330));
        3: qy = 11'($urandom_range(210, 230));
        default: qy = 11'($urandom_range(0, 2047));
      endcase
      if ($urandom_range(0, 5) == 0)
        cfg_write(7, 1'($urandom), int'(qx) - 5, int'(qx) + 5, int'(qy) - 3, int'(qy) + 3);
      run_query(int'($urandom_range(0, 1)), qx, qy);
    end
    for (int n = 0; n < 20; n++) begin
      logic exp_on;
      pix_hcount = 11'($urandom_range(0, 1000));
      pix_vcount = 11'($urandom_range(200, 620));
      exp_on = ref_pix(pix_hcount, pix_vcount);
      @(negedge clk);
      n_checks++;
      if (pix_on !== exp_on)
        $display("FAIL pix_random (%0d,%0d): pix_on=%0d required %0d", pix_hcount, pix_vcount, pix_on, exp_on);
      else n_pass++;
    end
  endtask

  task automatic test_rst_midscan();
    bit stray = 0;
    pix_hcount = 0; pix_vcount = 0;
    req0 = 1; x0 = 11'd300; y0 = 11'd600;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL midscan_busy: busy=%0d required 1", busy);
    else n_pass++;
    rst = 1; req0 = 0;
    @(negedge clk);
    n_checks++;
    if ({ack0, ack1, res_hit, res_idx, res_ytop, busy, cfg_ready, pix_on} !== {1'b0, 1'b0, 1'b0, 3'd0, 11'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL midscan_reset: ack0=%0d ack1=%0d hit=%0d idx=%0d ytop=%0d busy=%0d ready=%0d pix=%0d required 0,0,0,0,0,0,1,0",
               ack0, ack1, res_hit, res_idx, res_ytop, busy, cfg_ready, pix_on);
    else n_pass++;
    rst = 0;
    model_reset();
    repeat (15) begin
      @(negedge clk);
      if (ack0 || ack1) stray = 1;
    end
    n_checks++;
    if (stray) $display("FAIL midscan_no_ack: ack seen after aborted scan, required none");
    else n_pass++;
    run_query(0, 11'd300, 11'd600);
    run_query(1, 11'd250, 11'd600);
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_gap();
    test_tie();
    test_cfg_busy();
    test_pix();
    test_cfg_priority();
    test_random();
    test_rst_midscan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/platform_arbiter.md
# platform_arbiter

Owns the platform geometry table: up to 8 rectangular platforms. Shares it between two character controllers (requester 0 and requester 1), which ask "is this foot position on a platform?" over a req/ack handshake, with round-robin arbitration and a sequential 8-entry scan. Also drives a registered per-pixel platform mask for the background drawer, and accepts runtime table writes from the game-level logic. Sits in the VGA clock domain next to the background and character drawing stages.

## Interface
- NUM_PLAT, 8, number of table entries; fixed, index width 3
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- req0, req1  in  1  query request, held high until the matching ack
- x0, x1  in  11  query foot x (pixel column)
- y0, y1  in  11  query foot y (pixel row)
- ack0, ack1  out  1  one-cycle pulse; result valid in the same cycle
- res_hit  out  1  foot lies inside an enabled platform
- res_idx  out  3  lowest matching entry index (0 if no hit)
- res_ytop  out  11  y_top of matching entry (0 if no hit)
- busy  out  1  scan in progress (state != IDLE)
- cfg_we  in  1  table write strobe
- cfg_idx  in  3  entry to write
- cfg_en  in  1  entry enable
- cfg_xmin, cfg_xmax, cfg_ytop, cfg_ybot  in  11 each  inclusive bounds
- cfg_ready  out  1  high when a write would be accepted (state == IDLE)
- pix_hcount, pix_vcount  in  11  current pixel position
- pix_on  out  1  registered: pixel inside any enabled entry

## Operation
- Reset table, inclusive bounds as {en, xmin..xmax, ytop..ybot}:
  - 0: 1, 181..649, 596..604
  - 1: 1, 781..919, 596..604
  - 2: 1, 1..249, 456..464
  - 3: 1, 501..599, 456..464
  - 4: 1, 601..974, 316..324
  - 5: 1, 126..449, 216..224
  - 6, 7: disabled, all fields 0
- Match rule for an entry: en && xmin<=x<=xmax && ytop<=y<=ybot. All comparisons are unsigned, 11-bit.
- FSM states:
  - IDLE
    - If cfg_we: write the entry; no grant this cycle.
    - Else if any req: grant and latch the granted x/y; clear the scan accumulators; go to SCAN with idx=0.
  - SCAN
    - Evaluate entry idx once per cycle.
    - On the first match, record hit/idx/ytop. Later matches are ignored, so the lowest index wins.
    - After idx=7, go to DONE.
  - DONE
    - Pulse ack of the granted requester.
    - Drive res_* from the accumulators and go to IDLE.
- Arbitration:
  - Single request: grant it.
  - Both requesting: grant the requester not served last.
  - The last-served register resets to 1, so requester 0 wins the first tie.
- res_* hold their value until the next DONE.
- cfg_we outside IDLE is ignored (no write, no queue).
- A requester whose req is still high in the IDLE cycle after its ack is treated as a new request.
- x/y changes after grant do not affect the running scan.
- Pixel path: pix_on <= OR over enabled entries of the match rule on pix_hcount/pix_vcount. It uses the current table, including a write made in the same cycle's previous edge.

## Timing
- Reset values:
  - state=IDLE; ack0=ack1=0; res_hit=0, res_idx=0, res_ytop=0
  - busy=0; cfg_ready=1; pix_on=0; last-served=1; table=defaults
- Query latency: req sampled high in IDLE at edge N gives SCAN at edges N+1..N+8, DONE at N+9, and the ack pulse during cycle N+9→N+10. Back in IDLE at N+10, the next grant is possible at edge N+10.
- Throughput: one query per 10 cycles.
- Table write: takes effect at the edge it is sampled in IDLE. A query granted at the next edge sees it.
- pix_on: 1-cycle latency from pix_hcount/pix_vcount.
- rst mid-scan aborts the scan: no ack, and outputs and table return to reset values next edge.

## Test plan
- After reset, req0 with x=300, y=600 → ack0 exactly 10 cycles after req assertion; res_hit=1, res_idx=0, res_ytop=596; ack1 stays 0.
- req1 with x=700, y=600 (in a gap) → ack1 pulse; res_hit=0, res_idx=0, res_ytop=0.
- req0 and req1 asserted in the same cycle and held → ack0 first, ack1 ten cycles later; a repeat of the tie serves 1 then 0 in strict alternation.
- Write entry 6 = {1, 200..300, 590..610} in IDLE, then query x=250, y=600 → res_idx=0, since the lower index wins. Disable entry 0 and repeat → res_idx=6, res_ytop=590.
- cfg_we while busy=1 → table unchanged; the next query still returns default results. Sweeping pix_* over (181,596), (180,596), (649,604), (650,604) → pix_on 1,0,1,0 one cycle later.
- Assert rst in the 4th SCAN cycle → no ack ever issued for that request; all outputs 0, busy=0, cfg_ready=1 on the next edge; table back to defaults.
